// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) to one-port memory arbiter with a registered grant.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise D wins ties.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [BE_WIDTH-1:0]   i_byte_enable,
    output logic                  i_resp,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [BE_WIDTH-1:0]   d_byte_enable,
    output logic                  d_resp,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [BE_WIDTH-1:0]   mem_byte_enable,
    input  logic                  mem_resp,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } req_t;

    state_t state, state_nxt;
    req_t   i_req_s, d_req_s, mem_req_s;
    logic   i_req, d_req, tie_to_d;

    // A simultaneous read+write is forwarded as a pure write.
    assign i_req_s = '{rd: i_read & ~i_write, wr: i_write, addr: i_address,
                       wdata: i_wdata, be: i_byte_enable};
    assign d_req_s = '{rd: d_read & ~d_write, wr: d_write, addr: d_address,
                       wdata: d_wdata, be: d_byte_enable};
    assign i_req   = i_read | i_write;
    assign d_req   = d_read | d_write;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_d;

    always_ff @(posedge clk) begin
        if (reset)
            last_d <= 1'b1;
        else if (state == IDLE && state_nxt != IDLE)
            last_d <= (state_nxt == D_BUSY);
    end

    assign tie_to_d = ~last_d;
`else
    assign tie_to_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (d_req && (!i_req || tie_to_d))
                    state_nxt = D_BUSY;
                else if (i_req)
                    state_nxt = I_BUSY;
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req_s = '0;
        if (state == I_BUSY)
            mem_req_s = i_req_s;
        else if (state == D_BUSY)
            mem_req_s = d_req_s;
    end

    assign mem_read        = mem_req_s.rd;
    assign mem_write       = mem_req_s.wr;
    assign mem_address     = mem_req_s.addr;
    assign mem_wdata       = mem_req_s.wdata;
    assign mem_byte_enable = mem_req_s.be;

    assign i_resp  = mem_resp && (state == I_BUSY);
    assign d_resp  = mem_resp && (state == D_BUSY);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level owner/latency model.
module tb_mem_arbiter;
    localparam int AW = 16, DW = 16, BW = 2;

    logic          clk = 1'b0, reset = 1'b1;
    logic          i_read = 0, i_write = 0, d_read = 0, d_write = 0;
    logic [AW-1:0] i_address = '0, d_address = '0, mem_address;
    logic [DW-1:0] i_wdata = '0, d_wdata = '0, mem_wdata, mem_rdata = '0, i_rdata, d_rdata;
    logic [BW-1:0] i_byte_enable = '0, d_byte_enable = '0, mem_byte_enable;
    logic          i_resp, d_resp, mem_read, mem_write, mem_resp = 1'b0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_byte_enable(i_byte_enable), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          act, rd, wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } agent_t;

    int vectors = 0, errors = 0;
    agent_t ia, da;
    int owner = 0;          // 0 none, 1 I, 2 D
    int last = 2;
    int cnt = 0, lat = 1, fixed_lat = 0;
    int mode = 0;           // 0 random, 1 both always reading, 2 quiet
    int cyc = 0, last_resp_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic agent_t new_req(input bit force_read);
        agent_t a;
        a.act = 1;
        if (force_read) begin
            a.rd = 1; a.wr = 0;
        end else begin
            case ($urandom_range(0, 3))
                0, 1:    begin a.rd = 1; a.wr = 0; end
                2:       begin a.rd = 0; a.wr = 1; end
                default: begin a.rd = 1; a.wr = 1; end
            endcase
        end
        a.addr  = AW'($urandom);
        a.wdata = DW'($urandom);
        a.be    = BW'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic step(input bit rst, input bit stray);
        bit exp_rd, exp_wr, resp_now;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        logic [BW-1:0] exp_be;
        int pick;
        @(negedge clk);
        cyc++;
        reset = rst;
        i_read = ia.act & ia.rd; i_write = ia.act & ia.wr;
        i_address = ia.addr; i_wdata = ia.wdata; i_byte_enable = ia.be;
        d_read = da.act & da.rd; d_write = da.act & da.wr;
        d_address = da.addr; d_wdata = da.wdata; d_byte_enable = da.be;
        if (owner != 0) begin
            cnt++;
            resp_now = (cnt == lat);
        end else begin
            resp_now = stray;
        end
        mem_resp = resp_now;
        mem_rdata = DW'($urandom);
        #1;
        exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
        if (owner == 1) begin
            exp_wr = ia.wr; exp_rd = ia.rd & ~ia.wr;
            exp_addr = ia.addr; exp_wdata = ia.wdata; exp_be = ia.be;
        end else if (owner == 2) begin
            exp_wr = da.wr; exp_rd = da.rd & ~da.wr;
            exp_addr = da.addr; exp_wdata = da.wdata; exp_be = da.be;
        end
        chk("mem_read", 32'(mem_read), 32'(exp_rd));
        chk("mem_write", 32'(mem_write), 32'(exp_wr));
        chk("mem_address", 32'(mem_address), 32'(exp_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        chk("mem_byte_enable", 32'(mem_byte_enable), 32'(exp_be));
        chk("i_resp", 32'(i_resp), 32'(owner == 1 && resp_now));
        chk("d_resp", 32'(d_resp), 32'(owner == 2 && resp_now));
        if (owner == 1 && resp_now) chk("i_rdata", 32'(i_rdata), 32'(mem_rdata));
        if (owner == 2 && resp_now) chk("d_rdata", 32'(d_rdata), 32'(mem_rdata));
        if (mode == 1 && (i_resp || d_resp)) begin
            if (last_resp_cyc >= 0) chk("resp_spacing", 32'(cyc - last_resp_cyc), 32'd3);
            last_resp_cyc = cyc;
        end
        @(posedge clk);
        if (rst) begin
            owner = 0; last = 2; cnt = 0;
            ia.act = 0; da.act = 0;
        end else if (owner == 0) begin
            pick = 0;
            if (ia.act && da.act) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                pick = (last == 2) ? 1 : 2;
`else
                pick = 2;
`endif
            end else if (da.act) pick = 2;
            else if (ia.act) pick = 1;
            if (pick != 0) begin
                owner = pick; last = pick; cnt = 0;
                lat = (mode == 1) ? 2 : (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
            end
        end else if (resp_now) begin
            if (owner == 1) ia.act = 0; else da.act = 0;
            owner = 0;
        end
        if (!rst) begin
            if (mode == 1) begin
                if (!ia.act) begin ia = new_req(1); ia.addr = 16'h0040; end
                if (!da.act) begin da = new_req(1); da.addr = 16'h1000; end
            end else if (mode == 0) begin
                if (!ia.act && $urandom_range(0, 2) == 0) ia = new_req(0);
                if (!da.act && $urandom_range(0, 2) == 0) da = new_req(0);
            end
        end
    endtask

    initial begin
        ia = '{default: '0}; da = '{default: '0};
        // reset, then check idle outputs
        mode = 2;
        step(1, 0);
        step(1, 1);
        step(0, 1);
        step(0, 0);

        // directed: D write, 1-cycle memory
        da.act = 1; da.rd = 0; da.wr = 1; da.addr = 16'h1234; da.wdata = 16'hBEEF; da.be = 2'b01;
        fixed_lat = 1;
        repeat (4) step(0, 0);

        // directed: I read at 0x0040, 3-cycle memory
        ia.act = 1; ia.rd = 1; ia.wr = 0; ia.addr = 16'h0040; ia.wdata = '0; ia.be = 2'b11;
        fixed_lat = 3;
        repeat (6) step(0, 0);

        // both ports reading continuously from reset, 2-cycle memory
        step(1, 0);
        mode = 1;
        last_resp_cyc = -1;
        repeat (40) step(0, 0);

        // reset in cycle 2 of a 5-cycle D read, stray mem_resp later
        mode = 2;
        step(1, 0);
        da.act = 1; da.rd = 1; da.wr = 0; da.addr = 16'h2222; da.be = 2'b11;
        fixed_lat = 5;
        step(0, 0);
        step(0, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 1);
        step(0, 0);

        // randomized traffic with random latency, stray responses and resets
        mode = 0;
        fixed_lat = 0;
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter for the pipelined LC-3b CPU. Shares a single physical memory (or unified L2) port between the instruction-fetch port (`i_*`) and the data-memory port (`d_*`) of `cpu_datapath`. Serializes transactions with a three-state FSM and returns each response only to the requester that owns the current grant. It sits between the datapath's memory ports and the memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: address width of all ports.
- `DATA_WIDTH`, 16: data width of all ports.
- `BE_WIDTH`, 2: byte-enable width, equal to `DATA_WIDTH/8`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1: clock; all state changes on the rising edge.
  - `reset`  in  1: synchronous, active-high reset.
- Instruction port:
  - `i_read`, `i_write`  in  1: instruction-port request strobes.
  - `i_address`  in  ADDR_WIDTH.
  - `i_wdata`  in  DATA_WIDTH.
  - `i_byte_enable`  in  BE_WIDTH.
  - `i_resp`  out  1: completion pulse for the instruction port.
  - `i_rdata`  out  DATA_WIDTH: read data for the instruction port.
- Data port: `d_read`, `d_write`, `d_address`, `d_wdata`, `d_byte_enable`, `d_resp`, `d_rdata`. Same widths and meanings as the instruction port.
- Memory side:
  - `mem_read`, `mem_write`  out  1: memory strobes.
  - `mem_address`  out  ADDR_WIDTH.
  - `mem_wdata`  out  DATA_WIDTH.
  - `mem_byte_enable`  out  BE_WIDTH.
  - `mem_resp`  in  1: memory completion.
  - `mem_rdata`  in  DATA_WIDTH: memory read data.

## Operation
- Requests and holding:
  - A port requests when its `read` or `write` is high.
  - The requester holds address, data, byte enable and strobe stable until its `resp`.
  - If `read` and `write` are both high, it is treated as a write.
- FSM states:
  - `IDLE`: no memory strobe driven.
  - `I_BUSY`: memory-side outputs are a combinational copy of the `i_*` request.
  - `D_BUSY`: memory-side outputs are a combinational copy of the `d_*` request.
- Transitions:
  - `IDLE` → `I_BUSY` when only the I port requests.
  - `IDLE` → `D_BUSY` when only the D port requests.
  - When both request, the winner is set by the priority rule in Configuration.
  - `x_BUSY` → `IDLE` on the cycle `mem_resp`=1. Otherwise it stays in `x_BUSY`.
- Responses:
  - `i_resp` = `mem_resp` AND state==`I_BUSY`.
  - `d_resp` = `mem_resp` AND state==`D_BUSY`.
  - A `mem_resp` received in `IDLE` is ignored.
- Read data: `i_rdata` and `d_rdata` are a continuous pass-through of `mem_rdata`. They are valid only while the matching `resp` is high.
- In `IDLE`, all memory-side outputs are 0: `mem_address`, `mem_wdata`, `mem_byte_enable`, `mem_read`, `mem_write`.
- A request dropped before its `resp` is a protocol violation. The FSM keeps the grant and forwards whatever the port now drives.

## Timing
- Reset values (cycle after `reset` is sampled high):
  - state=`IDLE`.
  - All `mem_*` outputs 0; `i_resp`=0, `d_resp`=0.
  - Last-grant register = D, so the first tie goes to I under round-robin.
- Reset mid-transaction:
  - The grant is abandoned and no `resp` is returned.
  - The memory must tolerate strobe deassertion without a response.
- Latency:
  - Request seen in `IDLE` at cycle 0; memory strobe asserted in cycle 1.
  - Earliest `resp` is in cycle 1, with a 1-cycle memory.
  - Any memory latency N gives a `resp` in cycle N.
- Turnaround:
  - One mandatory `IDLE` cycle follows each completion.
  - Back-to-back transactions therefore start at best every N+1 cycles.
  - An always-asserted `i_read` (the datapath's fetch) is re-arbitrated in that `IDLE` cycle.
- Grant is registered; request sampling is only done in `IDLE`. A request arriving mid-transaction waits.
- `resp` is high for exactly one cycle per transaction: the cycle `mem_resp` is high.

## Configuration
- Macro: `MEM_ARBITER_ROUND_ROBIN_EN`.
- Defined:
  - On a tie in `IDLE`, grant goes to the port that did not win the last grant.
  - The last-grant register updates on every `IDLE` → `x_BUSY` transition.
- Undefined:
  - On a tie, D always wins; the last-grant register is not built.
  - The I port can starve under continuous D traffic, and this is accepted.

## Test plan
- Reset, then `i_read`=1, `i_address`=0x0040, memory latency 3: `mem_read`=1 with `mem_address`=0x0040 from cycle 1. `i_resp`=1 only in cycle 3 with `i_rdata`=`mem_rdata`. `d_resp` stays 0.
- `d_write`=1, `d_address`=0x1234, `d_wdata`=0xBEEF, `d_byte_enable`=2'b01, 1-cycle memory: `mem_write`=1 and the memory-side copy matches. `d_resp` pulses once, then state returns to `IDLE` for one cycle.
- `i_read` and `d_read` both high from reset, 2-cycle memory, round-robin defined: grants go I, D, I, D. Each `resp` pulse is 3 cycles apart.
- Same stimulus with the macro undefined: D is granted every transaction and `i_resp` never asserts.
- `reset` asserted in cycle 2 of a 5-cycle D read: next cycle `mem_read`=0 and state=`IDLE`. A stray `mem_resp` in cycle 5 produces no `i_resp` or `d_resp`.
